// File: rtl/openram_march_bist.sv
// March C- built-in self test controller for an OpenRAM single-port SRAM.
// Runs E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0);
// E5 down(r0) against a latched data background and records miscompares.
module openram_march_bist #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WMASK_WIDTH = 4,
    parameter int RD_LAT      = 1,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   stop_on_fail,
    input  logic [DATA_WIDTH-1:0]  bg,
    output logic                   csb,
    output logic                   web,
    output logic [WMASK_WIDTH-1:0] wmask,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [DATA_WIDTH-1:0]  din,
    input  logic [DATA_WIDTH-1:0]  dout,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [2:0]             fail_elem,
    output logic [CNT_WIDTH-1:0]   fail_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CMP,
        DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_t                 state, state_n;
    logic [2:0]             elem, elem_n;
    logic                   op_idx, op_n;
    logic [1:0]             lat_cnt, lat_n;
    logic [DATA_WIDTH-1:0]  bg_q;

    logic                   csb_n, web_n;
    logic [WMASK_WIDTH-1:0] wmask_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [DATA_WIDTH-1:0]  din_n;

    logic                   last_op, down, addr_last, seq_end;
    logic [2:0]             nxt_elem;
    logic [ADDR_WIDTH-1:0]  nxt_addr;
    logic                   nxt_op;

    logic                   start_acc, check, done_set, issue, is_wr;
    logic [2:0]             iss_elem;
    logic [ADDR_WIDTH-1:0]  iss_addr;
    logic                   iss_op;
    logic [DATA_WIDTH-1:0]  src;

    logic [DATA_WIDTH-1:0]  exp_data;
    logic                   miscmp;

    assign busy = (state == WR) || (state == RD) || (state == CMP);

    // Expected read value: elements 2 and 4 read "1" (~bg), the others read "0" (bg)
    always_comb begin
        exp_data = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg_q : bg_q;
        miscmp   = (dout != exp_data);
    end

    // Position of the op that follows the current one (elem, addr, op index)
    always_comb begin
        last_op   = (elem == 3'd0) || (elem == 3'd5) || op_idx;
        down      = (elem >= 3'd3);
        addr_last = down ? (addr == '0) : (addr == '1);
        nxt_elem  = elem;
        nxt_addr  = addr;
        nxt_op    = 1'b0;
        seq_end   = 1'b0;
        if (!last_op) begin
            nxt_op = 1'b1;
        end else if (addr_last) begin
            if (elem == 3'd5) begin
                seq_end = 1'b1;
            end else begin
                nxt_elem = elem + 3'd1;
                nxt_addr = (elem >= 3'd2) ? '1 : '0;
            end
        end else begin
            nxt_addr = down ? (addr - ADDR_WIDTH'(1)) : (addr + ADDR_WIDTH'(1));
        end
    end

    // Next-state and next SRAM-port values; SRAM outputs are registered
    always_comb begin
        state_n   = state;
        elem_n    = elem;
        op_n      = op_idx;
        lat_n     = lat_cnt;
        csb_n     = 1'b1;
        web_n     = 1'b1;
        wmask_n   = wmask;
        addr_n    = addr;
        din_n     = din;
        start_acc = 1'b0;
        check     = 1'b0;
        done_set  = 1'b0;
        issue     = 1'b0;
        is_wr     = 1'b0;
        iss_elem  = nxt_elem;
        iss_addr  = nxt_addr;
        iss_op    = nxt_op;
        src       = bg_q;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_acc = 1'b1;
                    issue     = 1'b1;
                    iss_elem  = 3'd0;
                    iss_addr  = '0;
                    iss_op    = 1'b0;
                    src       = bg;
                end
            end
            WR: begin
                if (seq_end) begin
                    state_n  = DONE;
                    done_set = 1'b1;
                end else begin
                    issue = 1'b1;
                end
            end
            RD: begin
                state_n = CMP;
                lat_n   = 2'd1;
            end
            CMP: begin
                if (lat_cnt == LAT_LAST) begin
                    check = 1'b1;
                    if ((miscmp && stop_on_fail) || seq_end) begin
                        state_n  = DONE;
                        done_set = 1'b1;
                    end else begin
                        issue = 1'b1;
                    end
                end else begin
                    lat_n = lat_cnt + 2'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (issue) begin
            is_wr   = (iss_elem == 3'd0) || iss_op;
            state_n = is_wr ? WR : RD;
            elem_n  = iss_elem;
            addr_n  = iss_addr;
            op_n    = iss_op;
            csb_n   = 1'b0;
            web_n   = !is_wr;
            if (is_wr) begin
                wmask_n = '1;
                din_n   = iss_elem[0] ? ~src : src;
            end
        end

        // Abort overrides everything, including the compare of this cycle
        if (abort && busy) begin
            state_n  = IDLE;
            elem_n   = elem;
            op_n     = op_idx;
            csb_n    = 1'b1;
            web_n    = 1'b1;
            wmask_n  = wmask;
            addr_n   = addr;
            din_n    = din;
            done_set = 1'b0;
            check    = 1'b0;
        end
    end

    // Sequencer state and registered SRAM port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            elem    <= '0;
            op_idx  <= 1'b0;
            lat_cnt <= '0;
            csb     <= 1'b1;
            web     <= 1'b1;
            wmask   <= '0;
            addr    <= '0;
            din     <= '0;
            bg_q    <= '0;
        end else begin
            state   <= state_n;
            elem    <= elem_n;
            op_idx  <= op_n;
            lat_cnt <= lat_n;
            csb     <= csb_n;
            web     <= web_n;
            wmask   <= wmask_n;
            addr    <= addr_n;
            din     <= din_n;
            if (start_acc) begin
                bg_q <= bg;
            end
        end
    end

    // Sticky completion flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (start_acc) begin
            done <= 1'b0;
        end else if (done_set) begin
            done <= 1'b1;
        end
    end

    // Miscompare bookkeeping: first-fail location and saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else if (start_acc) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
        end else if (check && miscmp) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= addr;
                fail_elem <= elem;
            end
            if (fail_count != '1) begin
                fail_count <= fail_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_openram_march_bist.sv
// Bench for openram_march_bist: two instances (RD_LAT 1 and 2) each with a
// behavioural SRAM that can hold one stuck-at bit; results compared against a
// loop-based March C- reference model and against hand-derived table values.
module tb_openram_march_bist;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int CW = 8;
    localparam int N  = 16;

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        int          sel;
        logic [31:0] bg;
        bit          fe;
        int          fa;
        int          fb;
        bit          fv;
        bit          sof;
        int          cyc;
        bit          fl;
        int          cnt;
        int          fad;
        int          fel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start_s [2];
    logic          abort_s [2];
    logic          sof_s   [2];
    logic [DW-1:0] bg_s    [2];
    logic [DW-1:0] dout_s  [2];
    logic [DW-1:0] din_s   [2];
    logic          csb_s   [2];
    logic          web_s   [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          fail_s  [2];
    logic [MW-1:0] wmask_s [2];
    logic [AW-1:0] addr_s  [2];
    logic [AW-1:0] faddr_s [2];
    logic [2:0]    felem_s [2];
    logic [CW-1:0] fcnt_s  [2];

    openram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .RD_LAT(1), .CNT_WIDTH(CW)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
        .stop_on_fail(sof_s[0]), .bg(bg_s[0]), .csb(csb_s[0]), .web(web_s[0]),
        .wmask(wmask_s[0]), .addr(addr_s[0]), .din(din_s[0]), .dout(dout_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .fail(fail_s[0]),
        .fail_addr(faddr_s[0]), .fail_elem(felem_s[0]), .fail_count(fcnt_s[0])
    );

    openram_march_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW), .RD_LAT(2), .CNT_WIDTH(CW)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
        .stop_on_fail(sof_s[1]), .bg(bg_s[1]), .csb(csb_s[1]), .web(web_s[1]),
        .wmask(wmask_s[1]), .addr(addr_s[1]), .din(din_s[1]), .dout(dout_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .fail(fail_s[1]),
        .fail_addr(faddr_s[1]), .fail_elem(felem_s[1]), .fail_count(fcnt_s[1])
    );

    // ---------------- SRAM models ----------------
    logic [DW-1:0] mem [2][N];
    bit            f_en   [2];
    int            f_addr [2];
    int            f_bit  [2];
    bit            f_val  [2];
    logic [DW-1:0] rd0, rd1_a, rd1_b;
    int            act;
    op_t           obs_q [$];

    assign dout_s[0] = rd0;
    assign dout_s[1] = rd1_b;

    function automatic logic [DW-1:0] rd_val(input int i);
        logic [DW-1:0] v;
        v = mem[i][addr_s[i]];
        if (f_en[i] && int'(addr_s[i]) == f_addr[i]) v[f_bit[i]] = f_val[i];
        return v;
    endfunction

    // Read pipelines, byte-masked writes and access log of the active instance
    always @(posedge clk) begin
        if (!csb_s[0] && web_s[0]) rd0 <= rd_val(0);
        if (!csb_s[1] && web_s[1]) rd1_a <= rd_val(1);
        rd1_b <= rd1_a;
        for (int i = 0; i < 2; i++) begin
            if (!csb_s[i] && !web_s[i]) begin
                for (int b = 0; b < MW; b++) begin
                    if (wmask_s[i][b]) mem[i][addr_s[i]][b*8 +: 8] = din_s[i][b*8 +: 8];
                end
            end
        end
        if (!csb_s[act]) obs_q.push_back('{we: !web_s[act], addr: int'(addr_s[act]), data: din_s[act]});
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;
    op_t exp_q [$];

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // March C- reference: walks elements/addresses as nested loops over a plain array
    function automatic void model_run(input int lat, input logic [31:0] bgv, input bit fe, input int fa,
                                      input int fb, input bit fv, input bit sof,
                                      output int cnt, output int fad, output int fel, output int cyc);
        logic [31:0] m [N];
        logic [31:0] r, e_v, w_v;
        int a;
        bit stop;
        exp_q.delete();
        cnt = 0; fad = 0; fel = 0; cyc = 0; stop = 0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int k = 0; k < N && !stop; k++) begin
                a = (e < 3) ? k : N - 1 - k;
                if (e > 0) begin
                    exp_q.push_back('{we: 1'b0, addr: a, data: '0});
                    cyc += 1 + lat;
                    r = m[a];
                    if (fe && a == fa) r[fb] = fv;
                    e_v = (e == 2 || e == 4) ? ~bgv : bgv;
                    if (r != e_v) begin
                        if (cnt == 0) begin fad = a; fel = e; end
                        if (cnt < 255) cnt++;
                        if (sof) stop = 1;
                    end
                end
                if (e < 5 && !stop) begin
                    w_v = (e % 2 == 1) ? ~bgv : bgv;
                    exp_q.push_back('{we: 1'b1, addr: a, data: w_v});
                    m[a] = w_v;
                    cyc += 1;
                end
            end
        end
    endfunction

    // One complete run on instance sel, compared against the reference model
    task automatic run_case(input int sel, input logic [31:0] bgv, input bit fe, input int fa, input int fb,
                            input bit fv, input bit sof, output int cyc, output int base);
        int m_cnt, m_fad, m_fel, m_cyc, n, bad;
        f_en[sel] = fe; f_addr[sel] = fa; f_bit[sel] = fb; f_val[sel] = fv;
        act  = sel;
        base = obs_q.size();
        model_run(sel + 1, bgv, fe, fa, fb, fv, sof, m_cnt, m_fad, m_fel, m_cyc);
        @(negedge clk);
        bg_s[sel] = bgv; sof_s[sel] = sof; start_s[sel] = 1'b1;
        @(negedge clk);
        start_s[sel] = 1'b0;
        chk("busy_rise", busy_s[sel], 1);
        chk("done_clr", done_s[sel], 0);
        cyc = 0;
        while (busy_s[sel] === 1'b1 && cyc < 3000) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_bounded", (cyc < 3000), 1);
        chk("busy_cycles", cyc, m_cyc);
        chk("done_at_fall", done_s[sel], 1);
        chk("fail", fail_s[sel], (m_cnt > 0));
        chk("fail_count", fcnt_s[sel], m_cnt);
        if (m_cnt > 0) begin
            chk("fail_addr", faddr_s[sel], m_fad);
            chk("fail_elem", felem_s[sel], m_fel);
        end
        @(negedge clk);
        chk("done_sticky", done_s[sel], 1);
        chk("csb_idle", csb_s[sel], 1);
        n = obs_q.size() - base;
        bad = -1;
        if (n == exp_q.size()) begin
            for (int i = 0; i < n; i++) begin
                op_t o;
                o = obs_q[base + i];
                if (o.we != exp_q[i].we || o.addr != exp_q[i].addr ||
                    (exp_q[i].we && o.data !== exp_q[i].data)) begin
                    bad = i;
                    break;
                end
            end
        end
        chk("trace_len", n, exp_q.size());
        chk("trace_first_bad", bad, -1);
    endtask

    vec_t vecs [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc, base, n0, bad, m_cnt, m_fad, m_fel, m_cyc;

        vecs[0] = '{0, 32'h0000_0000, 0, 0,  0, 0, 0, 240, 0, 0, 0,  0};
        vecs[1] = '{0, 32'h0000_0000, 1, 7,  5, 1, 0, 240, 1, 3, 7,  1};
        vecs[2] = '{0, 32'h0000_0000, 1, 7,  5, 1, 1, 39,  1, 1, 7,  1};
        vecs[3] = '{1, 32'hA5A5_5A5A, 0, 0,  0, 0, 0, 320, 0, 0, 0,  0};
        vecs[4] = '{0, 32'hFFFF_FFFF, 1, 0, 31, 0, 0, 240, 1, 3, 0,  1};
        vecs[5] = '{0, 32'h0000_0000, 1, 15, 0, 0, 1, 111, 1, 1, 15, 2};
        vecs[6] = '{1, 32'hA5A5_5A5A, 1, 3,  1, 1, 0, 320, 1, 2, 3,  2};

        act = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 0; abort_s[i] = 0; sof_s[i] = 0; bg_s[i] = '0;
            f_en[i] = 0; f_addr[i] = 0; f_bit[i] = 0; f_val[i] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_csb", csb_s[0], 1);
        chk("rst_web", web_s[0], 1);
        chk("rst_wmask", wmask_s[0], 0);
        chk("rst_busy", busy_s[0], 0);
        chk("rst_done", done_s[0], 0);
        chk("rst_fail_count", fcnt_s[1], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven directed runs
        for (int i = 0; i < 7; i++) begin
            run_case(vecs[i].sel, vecs[i].bg, vecs[i].fe, vecs[i].fa, vecs[i].fb, vecs[i].fv,
                     vecs[i].sof, cyc, base);
            chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
            chk($sformatf("vec%0d_fail", i), fail_s[vecs[i].sel], vecs[i].fl);
            chk($sformatf("vec%0d_count", i), fcnt_s[vecs[i].sel], vecs[i].cnt);
            if (vecs[i].fl) begin
                chk($sformatf("vec%0d_faddr", i), faddr_s[vecs[i].sel], vecs[i].fad);
                chk($sformatf("vec%0d_felem", i), felem_s[vecs[i].sel], vecs[i].fel);
            end
            if (i == 3 && obs_q.size() > base + 17) begin
                chk("e0_din", obs_q[base].data, 32'hA5A5_5A5A);
                chk("e1_din", obs_q[base + 17].data, 32'h5A5A_A5A5);
            end
        end

        // randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            run_case(int'($urandom_range(1, 0)), $urandom, bit'($urandom_range(1, 0)),
                     int'($urandom_range(N - 1, 0)), int'($urandom_range(DW - 1, 0)),
                     bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)), cyc, base);
        end

        // abort at busy cycle 50, with an ignored start pulse at cycle 30
        f_en[0] = 1; f_addr[0] = 7; f_bit[0] = 5; f_val[0] = 1;
        act = 0;
        model_run(1, 32'h0, 1, 7, 5, 1, 0, m_cnt, m_fad, m_fel, m_cyc);
        base = obs_q.size();
        @(negedge clk);
        bg_s[0] = '0; sof_s[0] = 0; start_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0;
        for (int c = 1; c < 50; c++) begin
            if (c == 30) start_s[0] = 1;
            if (c == 31) start_s[0] = 0;
            @(negedge clk);
        end
        chk("busy_c50", busy_s[0], 1);
        abort_s[0] = 1;
        @(negedge clk);
        abort_s[0] = 0;
        chk("abort_busy", busy_s[0], 0);
        chk("abort_csb", csb_s[0], 1);
        chk("abort_done", done_s[0], 0);
        chk("abort_fail", fail_s[0], 1);
        chk("abort_fcnt", fcnt_s[0], 1);
        chk("abort_faddr", faddr_s[0], 7);
        chk("abort_felem", felem_s[0], 1);
        n0 = obs_q.size() - base;
        bad = -1;
        for (int i = 0; i < n0 && i < exp_q.size(); i++) begin
            if (obs_q[base + i].we != exp_q[i].we || obs_q[base + i].addr != exp_q[i].addr) begin
                bad = i;
                break;
            end
        end
        chk("abort_trace_len", n0, 39);
        chk("abort_trace_bad", bad, -1);
        repeat (10) @(negedge clk);
        chk("abort_no_access", obs_q.size() - base, n0);

        // start and abort together in IDLE: abort wins
        start_s[0] = 1; abort_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0; abort_s[0] = 0;
        chk("sa_busy", busy_s[0], 0);
        repeat (5) @(negedge clk);
        chk("sa_no_access", obs_q.size() - base, n0);
        chk("sa_fcnt_kept", fcnt_s[0], 1);

        // asynchronous reset at busy cycle 100
        @(negedge clk);
        start_s[0] = 1;
        @(negedge clk);
        start_s[0] = 0;
        for (int c = 1; c < 100; c++) @(negedge clk);
        chk("pre_rst_fail", fail_s[0], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_csb", csb_s[0], 1);
        chk("arst_web", web_s[0], 1);
        chk("arst_wmask", wmask_s[0], 0);
        chk("arst_addr", addr_s[0], 0);
        chk("arst_din", din_s[0], 0);
        chk("arst_busy", busy_s[0], 0);
        chk("arst_done", done_s[0], 0);
        chk("arst_fail", fail_s[0], 0);
        chk("arst_faddr", faddr_s[0], 0);
        chk("arst_felem", felem_s[0], 0);
        chk("arst_fcnt", fcnt_s[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = obs_q.size();
        repeat (20) @(negedge clk);
        chk("rst_no_access", obs_q.size() - base, 0);
        chk("rst_idle_busy", busy_s[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
